// File: rtl/fetch_stage.sv
// Instruction-fetch front end: owns the PC, drives instruction memory and holds the IF/ID
// register, with stall, redirect (one bubble), HALT state and a fetched-instruction counter.
module fetch_stage #(
    parameter int unsigned              PC_W      = 5,
    parameter int unsigned              INSTR_W   = 32,
    parameter logic [INSTR_W-1:0]       HALT_WORD = 32'hFFFF_FFFF,
    parameter int unsigned              CNT_W     = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               stall,
    input  logic               redirect_valid,
    input  logic [PC_W-1:0]    redirect_pc,
    output logic [PC_W-1:0]    imem_addr,
    input  logic [INSTR_W-1:0] imem_data,
    output logic [INSTR_W-1:0] instr_id,
    output logic [PC_W-1:0]    pc_id,
    output logic               valid_id,
    output logic               halted,
    output logic [CNT_W-1:0]   fetch_count
);

    typedef enum logic [0:0] {StRun, StHalt} state_e;

    state_e             state_q, state_d;
    logic [PC_W-1:0]    pc_q, pc_d;
    logic [INSTR_W-1:0] instr_q, instr_d;
    logic [PC_W-1:0]    pc_id_q, pc_id_d;
    logic               valid_q, valid_d;
    logic               halted_q, halted_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        instr_d  = instr_q;
        pc_id_d  = pc_id_q;
        valid_d  = valid_q;
        cnt_d    = cnt_q;

        // Redirect beats stall: the IF/ID slot becomes a NOP bubble while the target is fetched.
        if (redirect_valid) begin
            pc_d    = redirect_pc;
            instr_d = '0;
            pc_id_d = '0;
            valid_d = 1'b0;
            state_d = StRun;
        end else if (!stall) begin
            unique case (state_q)
                StRun: begin
                    instr_d = imem_data;
                    pc_id_d = pc_q;
                    valid_d = 1'b1;
                    cnt_d   = cnt_q + 1'b1;
                    if (imem_data == HALT_WORD) begin
                        state_d = StHalt;
                    end else begin
                        pc_d = pc_q + 1'b1;
                    end
                end
                StHalt: begin
                    instr_d = '0;
                    pc_id_d = '0;
                    valid_d = 1'b0;
                end
                default: state_d = StRun;
            endcase
        end

        halted_d = (state_d == StHalt);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= StRun;
            pc_q     <= '0;
            instr_q  <= '0;
            pc_id_q  <= '0;
            valid_q  <= 1'b0;
            halted_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            instr_q  <= instr_d;
            pc_id_q  <= pc_id_d;
            valid_q  <= valid_d;
            halted_q <= halted_d;
            cnt_q    <= cnt_d;
        end
    end

    assign imem_addr   = pc_q;
    assign instr_id    = instr_q;
    assign pc_id       = pc_id_q;
    assign valid_id    = valid_q;
    assign halted      = halted_q;
    assign fetch_count = cnt_q;

endmodule
